// File: rtl/sdet_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// fill-state encoding, legal parameter limits and small elaboration helpers.
package sdet_pkg;

  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_FILLING = 2'd1,
    FILL_ARMED   = 2'd2
  } fill_state_e;

  localparam int PLEN_MIN  = 2;
  localparam int PLEN_MAX  = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

  // Fill counter must represent 0..plen inclusive.
  function automatic int fill_width(input int plen);
    return $clog2(plen + 1);
  endfunction

  function automatic bit cfg_legal(input int plen, input int cnt_w);
    return (plen >= PLEN_MIN) && (plen <= PLEN_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage

// File: rtl/seq_det_prog_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: masked compare of the last PLEN accepted
// bits against pattern, optional overlap, registered pulse and saturating match count.
module seq_det_prog
  import sdet_pkg::*;
#(
  parameter int PLEN  = 4,
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic             i,
  input  logic [PLEN-1:0]  pattern,
  input  logic [PLEN-1:0]  mask,
  input  logic             overlap,
  input  logic             clr,
  output logic             o,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = fill_width(PLEN);

  generate
    if (!cfg_legal(PLEN, CNT_W)) begin : g_bad_cfg
      $error("seq_det_prog: PLEN or CNT_W outside legal range");
    end
  endgenerate

  fill_state_e     state_reg;
  logic [FW-1:0]   fill_reg;
  logic [PLEN-1:0] hist_reg;
  logic [PLEN-1:0] hist_next;
  logic            o_reg;
  logic            accept;
  logic            full_next;
  logic            hit;

  assign accept    = i_valid & ~clr;
  assign hist_next = {hist_reg[PLEN-2:0], i};

  // History is complete after this bit if already armed or one bit short.
  assign full_next = (state_reg == FILL_ARMED) || (fill_reg == FW'(PLEN - 1));
  assign hit       = accept && full_next && (((hist_next ^ pattern) & mask) == '0);

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FILL_EMPTY;
      fill_reg  <= '0;
      hist_reg  <= '0;
      o_reg     <= 1'b0;
    end else if (clr) begin
      state_reg <= FILL_EMPTY;
      fill_reg  <= '0;
      hist_reg  <= '0;
      o_reg     <= 1'b0;
    end else begin
      o_reg <= hit;
      if (i_valid) begin
        hist_reg <= hist_next;
        if (hit && !overlap) begin
          // Non-overlapping mode: the matched bits may not be reused.
          state_reg <= FILL_EMPTY;
          fill_reg  <= '0;
        end else if (full_next) begin
          state_reg <= FILL_ARMED;
          fill_reg  <= FW'(PLEN);
        end else begin
          state_reg <= FILL_FILLING;
          fill_reg  <= fill_reg + 1'b1;
        end
      end
    end
  end

  sat_cnt #(
    .W(CNT_W)
  ) u_sat_cnt (
    .ck      (ck),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (hit),
    .q       (match_cnt)
  );

  assign o = o_reg;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: three instances (PLEN 4/3/4, CNT_W 8/8/2) checked each cycle
// against a queue-based model of accepted bits, plus directed scenarios.
module tb_seq_det_prog;

  logic       ck = 1'b0;
  logic       reset_n = 1'b1;
  logic       i_valid = 1'b0;
  logic       i = 1'b0;
  logic       overlap = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] pat4 = '0;
  logic [3:0] msk4 = '0;
  logic [2:0] pat3 = '0;
  logic [2:0] msk3 = '0;

  logic       o_a, o_b, o_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int total = 0;
  int bad   = 0;

  bit   hq[3][$];
  logic exp_o[3];
  int   exp_cnt[3];

  always #5 ck = ~ck;

  seq_det_prog #(.PLEN(4), .CNT_W(8)) u_dut_a (
    .ck(ck), .reset_n(reset_n), .i_valid(i_valid), .i(i), .pattern(pat4), .mask(msk4),
    .overlap(overlap), .clr(clr), .o(o_a), .match_cnt(cnt_a));

  seq_det_prog #(.PLEN(3), .CNT_W(8)) u_dut_b (
    .ck(ck), .reset_n(reset_n), .i_valid(i_valid), .i(i), .pattern(pat3), .mask(msk3),
    .overlap(overlap), .clr(clr), .o(o_b), .match_cnt(cnt_b));

  seq_det_prog #(.PLEN(4), .CNT_W(2)) u_dut_c (
    .ck(ck), .reset_n(reset_n), .i_valid(i_valid), .i(i), .pattern(pat4), .mask(msk4),
    .overlap(overlap), .clr(clr), .o(o_c), .match_cnt(cnt_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  function automatic int plen_of(input int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic int cmax_of(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  // Last plen accepted bits, oldest first, compared against pattern MSB-first.
  function automatic bit window_hit(input int k);
    int          plen = plen_of(k);
    int          n = hq[k].size();
    logic [15:0] pat = (k == 1) ? 16'(pat3) : 16'(pat4);
    logic [15:0] msk = (k == 1) ? 16'(msk3) : 16'(msk4);
    if (n < plen) return 1'b0;
    for (int j = 0; j < plen; j++) begin
      int idx = plen - 1 - j;
      if (msk[idx] && (hq[k][n - plen + j] != pat[idx])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      hq[k].delete();
      exp_o[k]   = 1'b0;
      exp_cnt[k] = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic b, input logic c);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        hq[k].delete();
        exp_o[k]   = 1'b0;
        exp_cnt[k] = 0;
      end else if (v) begin
        bit m;
        hq[k].push_back(b);
        if (hq[k].size() > 16) void'(hq[k].pop_front());
        m = window_hit(k);
        exp_o[k] = m;
        if (m) begin
          if (exp_cnt[k] < cmax_of(k)) exp_cnt[k]++;
          if (!overlap) hq[k].delete();
        end
      end else begin
        exp_o[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "/o_a"}, 32'(o_a), 32'(exp_o[0]));
    check_eq({tag, "/o_b"}, 32'(o_b), 32'(exp_o[1]));
    check_eq({tag, "/o_c"}, 32'(o_c), 32'(exp_o[2]));
    check_eq({tag, "/cnt_a"}, 32'(cnt_a), 32'(exp_cnt[0]));
    check_eq({tag, "/cnt_b"}, 32'(cnt_b), 32'(exp_cnt[1]));
    check_eq({tag, "/cnt_c"}, 32'(cnt_c), 32'(exp_cnt[2]));
  endtask

  task automatic cycle(input logic v, input logic b, input logic c);
    i_valid = v;
    i       = b;
    clr     = c;
    @(posedge ck);
    model_edge(v, b, c);
    #1;
    check_all("cyc");
  endtask

  function automatic logic get_o(input int k);
    return (k == 0) ? o_a : ((k == 1) ? o_b : o_c);
  endfunction

  // Feed n bits (MSB of the n-bit field first) with optional idle gaps; pulses[j] = o after bit j.
  task automatic run_bits(input logic [15:0] bits, input int n, input int gaps,
                          input int k, output logic [15:0] pulses);
    pulses = '0;
    for (int j = 0; j < n; j++) begin
      repeat (gaps) cycle(1'b0, 1'($urandom), 1'b0);
      cycle(1'b1, bits[n - 1 - j], 1'b0);
      if (get_o(k)) pulses[j] = 1'b1;
    end
  endtask

  // Called at posedge+1: pulls reset low between edges and checks it acts immediately.
  task automatic async_reset();
    #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all("arst");
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] rnd;

    model_clear();
    #1 reset_n = 1'b0;
    #2 check_all("reset");
    repeat (2) @(posedge ck);
    #1 check_all("reset_hold");
    reset_n = 1'b1;

    // Overlapping 1011 on stream 1011011
    pat4 = 4'b1011; msk4 = 4'hF; pat3 = 3'b111; msk3 = 3'b111; overlap = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    run_bits(16'b1011011, 7, 0, 0, p);
    check_eq("ovl_pulses", 32'(p), 32'h48);
    check_eq("ovl_cnt", 32'(cnt_a), 32'd2);

    // Same stream, non-overlapping
    overlap = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    run_bits(16'b1011011, 7, 0, 0, p);
    check_eq("novl_pulses", 32'(p), 32'h08);
    check_eq("novl_cnt", 32'(cnt_a), 32'd1);

    // PLEN=3 pattern 111, with and without idle gaps
    overlap = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    run_bits(16'b111101, 6, 0, 1, p);
    check_eq("p3_pulses", 32'(p), 32'h0C);
    check_eq("p3_cnt", 32'(cnt_b), 32'd2);
    cycle(1'b0, 1'b0, 1'b1);
    run_bits(16'b111101, 6, 2, 1, p);
    check_eq("p3_gap_pulses", 32'(p), 32'h0C);
    check_eq("p3_gap_cnt", 32'(cnt_b), 32'd2);

    // All don't-care mask, small counter saturates
    pat4 = 4'hF; msk4 = 4'h0;
    cycle(1'b0, 1'b0, 1'b1);
    rnd = 16'($urandom);
    run_bits(rnd, 8, 0, 2, p);
    check_eq("dc_pulses", 32'(p), 32'hF8);
    check_eq("dc_cnt_sat", 32'(cnt_c), 32'd3);

    // Async reset mid-pattern, then full refill needed; clr beats completing bit
    pat4 = 4'b1011; msk4 = 4'hF;
    cycle(1'b0, 1'b0, 1'b1);
    run_bits(16'b101, 3, 0, 0, p);
    async_reset();
    run_bits(16'b1011, 4, 0, 0, p);
    check_eq("arst_pulses", 32'(p), 32'h08);
    check_eq("arst_cnt", 32'(cnt_a), 32'd1);
    run_bits(16'b101, 3, 0, 0, p);
    cycle(1'b1, 1'b1, 1'b1);
    check_eq("clr_o", 32'(o_a), 32'd0);
    check_eq("clr_cnt", 32'(cnt_a), 32'd0);

    // Randomized traffic with live pattern/mask/overlap changes
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        pat4    = 4'($urandom);
        msk4    = 4'($urandom);
        pat3    = 3'($urandom);
        msk3    = 3'($urandom);
        overlap = 1'($urandom);
      end
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
